// File: rtl/usb_serial_tx.sv
// USB serialiser / line driver.
// Takes packet bytes over a valid/ready stream, prepends SYNC, NRZI-encodes
// LSB-first with bit stuffing, appends EOP and drives D+/D- with output enable.
// Each clk cycle is one line symbol; full/low speed is latched per packet.
module usb_serial_tx #(
    parameter int SYNC_BITS      = 8,
    parameter int STUFF_LEN      = 6,
    parameter int EOP_SE0_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ls_mode,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       d_plus,
    output logic       d_minus,
    output logic       tx_oe,
    output logic       busy,
    output logic       underrun
);

    typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP_SE0, EOP_J} state_t;

    localparam logic [7:0] SYNC_LAST = 8'(SYNC_BITS - 1);
    localparam logic [7:0] STUFF_MAX = 8'(STUFF_LEN);
    localparam logic [7:0] EOP_LAST  = 8'(EOP_SE0_CYCLES - 1);
    localparam logic [7:0] BIT_LAST  = 8'd7;

    state_t     state, state_n;
    logic [7:0] cnt, cnt_n;
    logic [7:0] ones, ones_n;
    logic [7:0] shifter, shifter_n;
    logic [7:0] hold_data;
    logic [7:0] load_byte;
    logic       shift_last, shift_last_n;
    logic       level, level_n;
    logic       ls_lat, ls_n;
    logic       hold_last, hold_full, last_seen;
    logic       accept, load, bypass;
    logic       emit_data, emit_bit;
    logic       sym_oe, sym_se0, line_ls, underrun_n;

    // A byte can only enter while the packet is still collecting data and
    // the packet's final byte has not been taken yet.
    assign tx_ready = !rst && !hold_full && !last_seen &&
                      (state == IDLE || state == SYNC || state == DATA);
    assign accept   = tx_valid && tx_ready;
    // A byte arriving exactly at the boundary goes straight to the shifter.
    assign bypass   = load && !hold_full;

    // Next-state, next line symbol and datapath control for the coming cycle.
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        ones_n       = ones;
        level_n      = level;
        shifter_n    = shifter;
        shift_last_n = shift_last;
        ls_n         = ls_lat;
        load         = 1'b0;
        emit_data    = 1'b0;
        emit_bit     = 1'b0;
        sym_oe       = 1'b1;
        sym_se0      = 1'b0;
        underrun_n   = 1'b0;
        load_byte    = hold_full ? hold_data : tx_data;

        case (state)
            IDLE: begin
                sym_oe = 1'b0;
                if (accept) begin
                    state_n   = SYNC;
                    ls_n      = ls_mode;
                    cnt_n     = '0;
                    sym_oe    = 1'b1;
                    emit_data = 1'b1;
                    emit_bit  = 1'b0;
                end
            end
            SYNC, DATA: begin
                if (state == SYNC && cnt != SYNC_LAST) begin
                    cnt_n     = cnt + 8'd1;
                    emit_data = 1'b1;
                    emit_bit  = (cnt_n == SYNC_LAST);
                end else if (ones == STUFF_MAX) begin
                    level_n = ~level;
                    ones_n  = '0;
                end else if (state == DATA && cnt != BIT_LAST) begin
                    cnt_n     = cnt + 8'd1;
                    shifter_n = {1'b0, shifter[7:1]};
                    emit_data = 1'b1;
                    emit_bit  = shifter[0];
                end else if (state == DATA && shift_last) begin
                    state_n = EOP_SE0;
                    cnt_n   = '0;
                    sym_se0 = 1'b1;
                end else if (hold_full || accept) begin
                    state_n      = DATA;
                    cnt_n        = '0;
                    load         = 1'b1;
                    shifter_n    = {1'b0, load_byte[7:1]};
                    shift_last_n = hold_full ? hold_last : tx_last;
                    emit_data    = 1'b1;
                    emit_bit     = load_byte[0];
                end else begin
                    underrun_n = 1'b1;
                    state_n    = EOP_SE0;
                    cnt_n      = '0;
                    sym_se0    = 1'b1;
                end
            end
            EOP_SE0: begin
                if (cnt != EOP_LAST) begin
                    cnt_n   = cnt + 8'd1;
                    sym_se0 = 1'b1;
                end else begin
                    state_n = EOP_J;
                    level_n = 1'b1;
                end
            end
            EOP_J: begin
                state_n = IDLE;
                sym_oe  = 1'b0;
                level_n = 1'b1;
            end
            default: begin
                state_n = IDLE;
                sym_oe  = 1'b0;
                level_n = 1'b1;
            end
        endcase

        if (emit_data) begin
            if (emit_bit) begin
                ones_n = ones + 8'd1;
            end else begin
                ones_n  = '0;
                level_n = ~level;
            end
        end

        line_ls = (state_n == IDLE) ? ls_mode : ls_n;
    end

    // FSM, shifter, counters and the one-byte holding register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            ones       <= '0;
            shifter    <= '0;
            shift_last <= 1'b0;
            level      <= 1'b1;
            ls_lat     <= 1'b0;
            hold_data  <= '0;
            hold_last  <= 1'b0;
            hold_full  <= 1'b0;
            last_seen  <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            ones       <= ones_n;
            shifter    <= shifter_n;
            shift_last <= shift_last_n;
            level      <= level_n;
            ls_lat     <= ls_n;
            if (accept && !bypass) begin
                hold_data <= tx_data;
                hold_last <= tx_last;
                hold_full <= 1'b1;
            end else if (load) begin
                hold_full <= 1'b0;
            end
            if (accept && tx_last) begin
                last_seen <= 1'b1;
            end else if (state == EOP_J) begin
                last_seen <= 1'b0;
            end
        end
    end

    // Registered line outputs: J/K mapped through the speed polarity, SE0 forces both low.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_plus   <= 1'b1;
            d_minus  <= 1'b0;
            tx_oe    <= 1'b0;
            busy     <= 1'b0;
            underrun <= 1'b0;
        end else begin
            d_plus   <= !sym_se0 && (level_n ^ line_ls);
            d_minus  <= !sym_se0 && !(level_n ^ line_ls);
            tx_oe    <= sym_oe;
            busy     <= sym_oe;
            underrun <= underrun_n;
        end
    end

endmodule

// File: tb/tb_usb_serial_tx.sv
// Bench for usb_serial_tx: a bit-level model builds the expected symbol stream
// {underrun, busy, tx_oe, d_plus, d_minus} per packet, and a monitor pops and
// compares one entry per clock once the packet's first byte is accepted.
module tb_usb_serial_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       ls_mode;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_ready;
    logic       d_plus;
    logic       d_minus;
    logic       tx_oe;
    logic       busy;
    logic       underrun;

    int         errors = 0;
    int         checks = 0;
    logic [4:0] exp_q[$];
    bit         armed = 1'b0;
    int         ready_cycles = 0;

    usb_serial_tx #(
        .SYNC_BITS(8),
        .STUFF_LEN(6),
        .EOP_SE0_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ls_mode(ls_mode),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_last(tx_last),
        .tx_ready(tx_ready),
        .d_plus(d_plus),
        .d_minus(d_minus),
        .tx_oe(tx_oe),
        .busy(busy),
        .underrun(underrun)
    );

    // Bit clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Line pair {d_plus, d_minus} for an NRZI level (1 = J) at a given speed.
    function automatic logic [1:0] line_sym(input logic lvl, input logic ls);
        return (lvl ^ ls) ? 2'b10 : 2'b01;
    endfunction

    // Scoreboard consumer: one expected symbol per cycle while a packet is armed.
    always @(negedge clk) begin
        logic [4:0] e;
        if (armed) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e[3] && tx_ready) ready_cycles++;
                checkOutput("line_symbol", 32'({underrun, busy, tx_oe, d_plus, d_minus}), 32'(e));
                if (exp_q.size() == 0) armed = 1'b0;
            end else begin
                armed = 1'b0;
            end
        end
    end

    // Builds the expected stream, then feeds bytes (valid held between bytes).
    // With starve set only the first byte is offered and the packet must abort.
    task automatic applyStimulus(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                                 input int n, input logic ls, input bit starve);
        logic [7:0] b[3];
        logic       raw[$];
        logic       lvl;
        logic       x;
        int         ones;
        int         nsend;
        int         w;
        b[0] = b0; b[1] = b1; b[2] = b2;
        nsend = starve ? 1 : n;
        ready_cycles = 0;
        for (int i = 0; i < 7; i++) raw.push_back(1'b0);
        raw.push_back(1'b1);
        for (int i = 0; i < nsend; i++)
            for (int j = 0; j < 8; j++) raw.push_back(b[i][j]);
        lvl  = 1'b1;
        ones = 0;
        for (int k = 0; k < raw.size(); k++) begin
            x = raw[k];
            if (!x) lvl = ~lvl;
            exp_q.push_back({1'b0, 2'b11, line_sym(lvl, ls)});
            if (x) begin
                ones++;
                if (ones == 6) begin
                    lvl = ~lvl;
                    exp_q.push_back({1'b0, 2'b11, line_sym(lvl, ls)});
                    ones = 0;
                end
            end else begin
                ones = 0;
            end
        end
        exp_q.push_back({starve, 2'b11, 2'b00});
        exp_q.push_back({1'b0, 2'b11, 2'b00});
        exp_q.push_back({1'b0, 2'b11, line_sym(1'b1, ls)});
        exp_q.push_back({1'b0, 2'b00, line_sym(1'b1, ls)});

        ls_mode = ls;
        for (int i = 0; i < nsend; i++) begin
            tx_data  = b[i];
            tx_last  = (i == n - 1);
            tx_valid = 1'b1;
            w = 0;
            while (!tx_ready && w < 200) begin
                @(negedge clk);
                w++;
            end
            if (!tx_ready) checkOutput("ready_timeout", 32'(tx_ready), 32'd1);
            @(posedge clk);
            #1;
            if (i == 0) armed = 1'b1;
        end
        tx_valid = 1'b0;
        tx_last  = 1'b0;

        w = 0;
        while (armed && w < 500) begin
            @(negedge clk);
            w++;
        end
        checkOutput("stream_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        armed = 1'b0;
        if (!starve) checkOutput("ready_pulses", 32'(ready_cycles), 32'(n - 1));
    endtask

    initial begin
        int w;
        rst      = 1'b1;
        ls_mode  = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_d_plus", 32'(d_plus), 32'd1);
        checkOutput("rst_d_minus", 32'(d_minus), 32'd0);
        checkOutput("rst_tx_oe", 32'(tx_oe), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_underrun", 32'(underrun), 32'd0);
        checkOutput("rst_tx_ready", 32'(tx_ready), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_rst", 32'(tx_ready), 32'd1);

        $display("[TB] full speed 0x00");
        applyStimulus(8'h00, 8'h00, 8'h00, 1, 1'b0, 1'b0);
        $display("[TB] full speed 0xFF with stuffing");
        applyStimulus(8'hFF, 8'h00, 8'h00, 1, 1'b0, 1'b0);
        $display("[TB] low speed 0x00");
        applyStimulus(8'h00, 8'h00, 8'h00, 1, 1'b1, 1'b0);
        $display("[TB] back-to-back three bytes");
        applyStimulus(8'hA5, 8'h3C, 8'h81, 3, 1'b0, 1'b0);
        $display("[TB] underrun abort");
        applyStimulus(8'h5A, 8'hC3, 8'h00, 2, 1'b0, 1'b1);

        $display("[TB] reset mid-packet");
        ls_mode  = 1'b0;
        tx_data  = 8'h00;
        tx_last  = 1'b1;
        tx_valid = 1'b1;
        w = 0;
        while (!tx_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        repeat (12) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midrst_tx_oe", 32'(tx_oe), 32'd0);
        checkOutput("midrst_d_plus", 32'(d_plus), 32'd1);
        checkOutput("midrst_d_minus", 32'(d_minus), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_tx_ready", 32'(tx_ready), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        $display("[TB] fresh packet after reset");
        applyStimulus(8'h96, 8'h00, 8'h00, 1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
